// File: rtl/aes_stream_sequencer.sv
// rtl/aes_stream_sequencer.sv - block sequencer between the 32-bit FIFO shell and the 8-bit AES core (option: AES_SEQ_TIMEOUT_EN)
module aes_stream_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  data_empty,
    output logic                  data_rd,
    input  logic [DATA_WIDTH-1:0] data_din,
    input  logic                  data_full,
    output logic                  data_wr,
    output logic [DATA_WIDTH-1:0] data_dout,
    output logic                  aes_rst,
    output logic                  aes_input_vld,
    output logic [7:0]            aes_key,
    output logic [7:0]            aes_din,
    input  logic [7:0]            aes_dout,
    input  logic                  aes_d_vld,
    output logic                  busy,
    output logic [15:0]           blocks_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        COLLECT,
        DRAIN
`ifdef AES_SEQ_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t      state;
    logic [7:0]  pair_key  [16];
    logic [7:0]  pair_data [16];
    logic [7:0]  out_byte  [16];
    logic [3:0]  ld_cnt;
    logic [3:0]  fd_cnt;
    logic [4:0]  col_cnt;
    logic [1:0]  wr_k;
    logic [31:0] drain_word;
    logic [15:0] unused_din;

    assign unused_din = data_din[31:16];
    assign busy       = (state != IDLE);
    assign data_rd    = (state == LOAD) && !data_empty;
    assign drain_word = {out_byte[{wr_k, 2'd3}], out_byte[{wr_k, 2'd2}],
                         out_byte[{wr_k, 2'd1}], out_byte[{wr_k, 2'd0}]};

`ifdef AES_SEQ_TIMEOUT_EN
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt;

    assign data_wr   = ((state == DRAIN) || (state == ERR)) && !data_full;
    assign data_dout = (state == ERR) ? {16'hDEAD, 8'h00, 3'b000, col_cnt} : drain_word;
`else
    logic [TW-1:0] unused_tmo;

    assign unused_tmo = TW'(TIMEOUT_CYCLES);
    assign data_wr    = (state == DRAIN) && !data_full;
    assign data_dout  = drain_word;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            ld_cnt        <= 4'd0;
            fd_cnt        <= 4'd0;
            col_cnt       <= 5'd0;
            wr_k          <= 2'd0;
            blocks_done   <= 16'd0;
            aes_rst       <= 1'b1;
            aes_input_vld <= 1'b0;
            aes_key       <= 8'd0;
            aes_din       <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                pair_key[i]  <= 8'd0;
                pair_data[i] <= 8'd0;
                out_byte[i]  <= 8'd0;
            end
`ifdef AES_SEQ_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            aes_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (!data_empty) begin
                        state  <= LOAD;
                        ld_cnt <= 4'd0;
                    end
                end
                LOAD: begin
                    if (!data_empty) begin
                        pair_key[ld_cnt]  <= data_din[15:8];
                        pair_data[ld_cnt] <= data_din[7:0];
                        ld_cnt            <= ld_cnt + 4'd1;
                        // Present pair 0 on the edge into FEED so the core sees 16 aligned cycles.
                        if (ld_cnt == 4'd15) begin
                            state         <= FEED;
                            fd_cnt        <= 4'd0;
                            aes_input_vld <= 1'b1;
                            aes_key       <= pair_key[0];
                            aes_din       <= pair_data[0];
                        end
                    end
                end
                FEED: begin
                    if (fd_cnt == 4'd15) begin
                        state         <= COLLECT;
                        fd_cnt        <= 4'd0;
                        aes_input_vld <= 1'b0;
                        col_cnt       <= 5'd0;
`ifdef AES_SEQ_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end else begin
                        fd_cnt  <= fd_cnt + 4'd1;
                        aes_key <= pair_key[fd_cnt + 4'd1];
                        aes_din <= pair_data[fd_cnt + 4'd1];
                    end
                end
                COLLECT: begin
                    if (aes_d_vld) begin
                        out_byte[col_cnt[3:0]] <= aes_dout;
                        col_cnt                <= col_cnt + 5'd1;
                        if (col_cnt == 5'd15) begin
                            state <= DRAIN;
                            wr_k  <= 2'd0;
                        end
                    end
`ifdef AES_SEQ_TIMEOUT_EN
                    if (!(aes_d_vld && col_cnt == 5'd15)) begin
                        if (tmo_cnt == TMO_MAX) begin
                            state   <= ERR;
                            aes_rst <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
`endif
                end
                DRAIN: begin
                    if (!data_full) begin
                        wr_k <= wr_k + 2'd1;
                        if (wr_k == 2'd3) begin
                            blocks_done <= blocks_done + 16'd1;
                            state       <= IDLE;
                        end
                    end
                end
`ifdef AES_SEQ_TIMEOUT_EN
                ERR: begin
                    if (!data_full) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// tb/tb_aes_stream_sequencer.sv - scoreboard bench with FIFO and core models for aes_stream_sequencer
module tb_aes_stream_sequencer;

    logic        clock = 1'b0;
    logic        reset_n, data_empty, data_rd, data_full, data_wr;
    logic        aes_rst, aes_input_vld, aes_d_vld, busy;
    logic [31:0] data_din, data_dout;
    logic [7:0]  aes_key, aes_din, aes_dout;
    logic [15:0] blocks_done;

    always #5 clock = ~clock;

    aes_stream_sequencer #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
        .clock(clock), .reset_n(reset_n), .data_empty(data_empty), .data_rd(data_rd),
        .data_din(data_din), .data_full(data_full), .data_wr(data_wr), .data_dout(data_dout),
        .aes_rst(aes_rst), .aes_input_vld(aes_input_vld), .aes_key(aes_key), .aes_din(aes_din),
        .aes_dout(aes_dout), .aes_d_vld(aes_d_vld), .busy(busy), .blocks_done(blocks_done)
    );

    int checks = 0, errors = 0;
    logic [31:0] in_q[$], exp_q[$];
    logic [15:0] feed_q[$];
    logic [7:0]  resp_q[$];
    logic [31:0] blk[16];
    logic [7:0]  rb[16];
    int fed = 0, run = 0, feeds = 0, pops = 0, words = 0, resp_avail = 0, resp_limit = 16;
    int cyc = 0, rst_pulses = 0, n = 0, w0 = 0, p0 = 0;
    bit gap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] core_f(input logic [7:0] k, input logic [7:0] d);
        return (k * 8'd29) ^ d ^ 8'h63;
    endfunction

    task automatic upd_in();
        data_empty = (in_q.size() == 0);
        data_din   = (in_q.size() == 0) ? 32'h0 : in_q[0];
    endtask

    task automatic prep(input logic [7:0] kb, input logic [7:0] db, input bit gapped, input int limit);
        for (int i = 0; i < 16; i++) begin
            blk[i] = {16'hC0DE, kb + 8'(i), db + 8'(i)};
            feed_q.push_back({kb + 8'(i), db + 8'(i)});
            rb[i] = gapped ? 8'hA0 + 8'(i) : core_f(kb + 8'(i), db + 8'(i));
            resp_q.push_back(rb[i]);
        end
        gap        = gapped;
        resp_limit = limit;
        if (limit == 16) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({rb[4*k+3], rb[4*k+2], rb[4*k+1], rb[4*k]});
        end else begin
            exp_q.push_back(32'hDEAD0000 | 32'(limit));
        end
    endtask

    task automatic push(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) in_q.push_back(blk[i]);
        upd_in();
    endtask

    // One clock: sample at negedge, update the FIFO and core models just after posedge.
    task automatic tick();
        logic        rd;
        logic [31:0] e;
        logic [15:0] f;
        @(negedge clock);
        if (aes_input_vld) begin
            if (run == 0) begin
                feeds++;
                chk("pops_before_feed", 32'(pops), 32'(16 * feeds));
            end
            run++;
            if (feed_q.size() > 0) f = feed_q.pop_front(); else f = 16'hxxxx;
            chk("feed_pair", 32'({aes_key, aes_din}), 32'(f));
            fed++;
            if (fed == 16) begin
                fed = 0;
                resp_avail = resp_limit;
            end
        end else if (run != 0) begin
            chk("feed_run", 32'(run), 32'd16);
            run = 0;
        end
        if (data_wr) begin
            chk("wr_while_full", 32'(data_full), 32'd0);
            words++;
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 32'hxxxxxxxx;
            chk("dout_word", data_dout, e);
        end
        if (reset_n && aes_rst) begin
            rst_pulses++;
            resp_q.delete();
            resp_avail = 0;
            fed = 0;
        end
        rd = data_rd;
        @(posedge clock);
        #1;
        cyc++;
        if (rd) begin
            e = in_q.pop_front();
            pops++;
        end
        upd_in();
        if (resp_avail > 0 && (!gap || (cyc % 3) == 0)) begin
            aes_d_vld  = 1'b1;
            aes_dout   = resp_q.pop_front();
            resp_avail--;
        end else begin
            aes_d_vld = 1'b0;
            aes_dout  = 8'h00;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((busy || exp_q.size() != 0 || in_q.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        chk("done_in_budget", 32'(c < budget), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        data_full = 1'b0;
        aes_d_vld = 1'b0;
        aes_dout  = 8'h00;
        upd_in();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_rd", 32'(data_rd), 32'd0);
        chk("rst_data_wr", 32'(data_wr), 32'd0);
        chk("rst_data_dout", data_dout, 32'd0);
        chk("rst_aes_rst", 32'(aes_rst), 32'd1);
        chk("rst_input_vld", 32'(aes_input_vld), 32'd0);
        chk("rst_key_din", 32'({aes_key, aes_din}), 32'd0);
        chk("rst_blocks_done", 32'(blocks_done), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        prep(8'h00, 8'h10, 1'b0, 16);
        push(0, 15);
        drain(200);
        chk("blocks_done_single", 32'(blocks_done), 32'd1);

        prep(8'h40, 8'h80, 1'b0, 16);
        push(0, 4);
        repeat (50) tick();
        chk("starved_no_feed", 32'(feeds), 32'd1);
        chk("starved_pops", 32'(pops), 32'd21);
        push(5, 15);
        drain(200);
        chk("blocks_done_starved", 32'(blocks_done), 32'd2);

        prep(8'h22, 8'h33, 1'b0, 16);
        data_full = 1'b1;
        w0 = words;
        push(0, 15);
        n = 0;
        while (resp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        repeat (20) tick();
        chk("bp_no_words", 32'(words - w0), 32'd0);
        chk("bp_blocks_held", 32'(blocks_done), 32'd2);
        data_full = 1'b0;
        drain(100);
        chk("bp_word_count", 32'(words - w0), 32'd4);
        chk("blocks_done_bp", 32'(blocks_done), 32'd3);

        prep(8'h55, 8'h66, 1'b1, 16);
        push(0, 15);
        drain(300);
        chk("blocks_done_gapped", 32'(blocks_done), 32'd4);

`ifdef AES_SEQ_TIMEOUT_EN
        p0 = rst_pulses;
        prep(8'h01, 8'h02, 1'b0, 7);
        push(0, 15);
        drain(400);
        chk("tmo_rst_pulses", 32'(rst_pulses - p0), 32'd1);
        chk("tmo_blocks_held", 32'(blocks_done), 32'd4);
        prep(8'h09, 8'h0A, 1'b0, 16);
        push(0, 15);
        drain(200);
        chk("blocks_done_after_tmo", 32'(blocks_done), 32'd5);
`endif

        prep(8'h70, 8'h71, 1'b0, 16);
        push(0, 15);
        n = 0;
        while (run < 8 && n < 200) begin
            tick();
            n++;
        end
        chk("reached_feed_8", 32'(run), 32'd8);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_input_vld", 32'(aes_input_vld), 32'd0);
        chk("midrst_aes_rst", 32'(aes_rst), 32'd1);
        chk("midrst_blocks_done", 32'(blocks_done), 32'd0);
        run = 0;
        fed = 0;
        feed_q.delete();
        exp_q.delete();
        resp_q.delete();
        resp_avail = 0;
        reset_n = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_stream_sequencer.md
# aes_stream_sequencer

Sequences the 8-bit serial AES core (aes_8_bit) from the 32-bit FIFO shell. It buffers one complete block of 16 key/data byte pairs from the input FIFO, then feeds them to the core on 16 back-to-back cycles. It collects the 16 result bytes, packs them four per word, and writes four words to the output FIFO under backpressure. It sits between the shell FIFOs and the core in place of the ad-hoc FSM in the top level, so FIFO stalls can never break the core's contiguous-input requirement.

## Interface
- DATA_WIDTH, 32, FIFO word width; must be 32.
- TIMEOUT_CYCLES, 1024, maximum COLLECT cycles before the error path is taken (used only with AES_SEQ_TIMEOUT_EN).
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset; clock clock.
- data_empty  in  1  input FIFO empty; FIFO is first-word fall-through.
- data_rd  out  1  input pop; combinational, asserted as (state==LOAD && !data_empty).
- data_din  in  32  input word: [7:0] data byte, [15:8] key byte, [31:16] ignored.
- data_full  in  1  output FIFO full.
- data_wr  out  1  output push; combinational, asserted as ((DRAIN or ERR) && !data_full).
- data_dout  out  32  output word; combinational mux of the packed buffer or the error word.
- aes_rst  out  1  core reset, registered: high during reset and for one cycle after a timeout.
- aes_input_vld  out  1  core input valid, registered.
- aes_key  out  8  key byte to core, registered.
- aes_din  out  8  data byte to core, registered.
- aes_dout  in  8  core result byte.
- aes_d_vld  in  1  core result valid.
- busy  out  1  high whenever state != IDLE.
- blocks_done  out  16  completed blocks, wraps at 65535 -> 0.

## Operation
- State reset values:
  - state IDLE; load, feed and collect counters 0.
  - Input and output buffers cleared.
  - blocks_done 0; aes_rst 1; aes_input_vld, aes_key and aes_din 0.
- Combinational output values during reset:
  - data_rd and data_wr are 0, because state is IDLE.
  - data_dout is 0, because the buffers are cleared.
- Reset mid-operation abandons the current block; the partial block is lost.
- IDLE: go to LOAD when data_empty is low. The transition does not pop.
- LOAD:
  - Each cycle with data_empty low, pop one word and store pair[ld_cnt].
  - data_empty high stalls with no pop and no state change.
  - After pair[15] is stored, go to FEED.
- FEED: exactly 16 cycles, never interrupted.
  - Cycle i: aes_input_vld=1, aes_key=pair[i].key, aes_din=pair[i].data.
  - After cycle 15, go to COLLECT.
  - aes_input_vld returns to 0 on the next edge.
- COLLECT:
  - Each cycle with aes_d_vld high, store aes_dout into out_byte[col_cnt] and increment col_cnt.
  - After the 16th byte, go to DRAIN.
  - aes_d_vld pulses need not be contiguous.
- DRAIN:
  - data_dout = {out_byte[4k+3], out_byte[4k+2], out_byte[4k+1], out_byte[4k]} for k = 0..3.
  - k advances only on cycles where data_wr is high.
  - After k=3 is written: increment blocks_done and go to IDLE.
- ERR (AES_SEQ_TIMEOUT_EN only):
  - data_dout = 32'hDEAD_00NN, with NN = col_cnt (bytes received).
  - Hold until data_wr is high, then go to IDLE.
  - blocks_done does not increment.
- aes_d_vld outside COLLECT is ignored.
- Arithmetic: load and feed counters are 4-bit; col_cnt is 5-bit; the timeout counter is clog2(TIMEOUT_CYCLES)+1 bits.

## Timing
- Minimum block latency is 1 + 16 + 16 + Tcore + 4 cycles, from data_empty falling to the last data_wr.
  - Tcore is the core latency from the first aes_input_vld to the 16th aes_d_vld, minus 16.
- Input pops never occur outside LOAD.
- aes_input_vld is high for exactly 16 consecutive cycles per block.
- data_wr is never high in a cycle where data_full is high.
- A push at full is impossible by construction.
- Throughput: one block per blocked pass; no overlap of LOAD with FEED, COLLECT or DRAIN.

## Configuration
- AES_SEQ_TIMEOUT_EN defined:
  - The timeout counter runs in COLLECT and clears on entry.
  - When it reaches TIMEOUT_CYCLES with col_cnt < 16: pulse aes_rst for 1 cycle and go to ERR.
- Undefined:
  - COLLECT waits indefinitely and the ERR state is absent.
  - aes_rst is simply ~reset_n.

## Test plan
- Single block: push 16 words with key=i and data=0x10+i, output FIFO empty -> aes_input_vld high for 16 consecutive cycles. aes_key/aes_din sequence 0..15 / 0x10..0x1F, then 4 words matching the reference AES bytes packed little-endian, and blocks_done=1.
- Input starvation: push 5 words, wait 50 cycles, push 11 more -> no aes_input_vld until the 16th pop, then 16 contiguous cycles.
- Output backpressure: hold data_full high during DRAIN for 20 cycles, then release -> no data_wr while full, then 4 words in order with none dropped or duplicated.
- Gapped core output: model asserts aes_d_vld in 16 non-contiguous cycles with bytes 0xA0..0xAF -> words 0xA3A2A1A0, 0xA7A6A5A4, 0xABAAA9A8, 0xAFAEADAC.
- Timeout (AES_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64): model returns only 7 bytes -> aes_rst 1-cycle pulse, one word 0xDEAD0007, blocks_done unchanged, then the next block processes normally.
- Reset mid-FEED: drive reset_n low at feed cycle 8 -> next cycle state IDLE, busy=0, aes_input_vld=0, aes_rst=1, blocks_done=0.
